// File: rtl/block_data_memory.sv
// Block-level backing store behind the data cache.
// Serves whole-block reads (miss fill) and writes (dirty write-back).
// Each access takes a fixed number of cycles, so the store behaves like
// slow main memory. While an access is in progress, busywait stalls the
// requester.
//
// state | meaning
// IDLE  | waiting for read or write; busywait follows the request
// BUSY  | latency down-counter running on captured request
// DONE  | access performed this cycle; busywait low for one cycle
module block_data_memory #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  busywait,
  output logic                  error,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [3:0]            lat_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  op_write_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic req;
  logic cnt_tc;
  logic do_access;

  assign req       = read | write;
  assign cnt_tc    = (lat_cnt == 4'd1);
  assign do_access = (state == BUSY) && cnt_tc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and busywait. In IDLE the stall is combinational from the
  // request, so the requester's first sampling edge already sees it.
  always_comb begin
    state_next = state;
    busywait   = 1'b0;
    case (state)
      IDLE: begin
        busywait = req;
        if (req) state_next = BUSY;
      end
      BUSY: begin
        busywait = 1'b1;
        if (cnt_tc) state_next = DONE;
      end
      DONE: begin
        busywait   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, latency countdown and sticky collision flag.
  // A simultaneous read and write is served as a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt    <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      error      <= 1'b0;
    end else if (state == IDLE && req) begin
      lat_cnt    <= LAT_LOAD;
      addr_q     <= address;
      wdata_q    <= writedata;
      op_write_q <= write;
      if (read && write) error <= 1'b1;
    end else if (state == BUSY && !cnt_tc) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // Storage array: cleared on reset, written when a captured write completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_access && op_write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Read data return and saturating completion counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (do_access) begin
      if (op_write_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        readdata <= mem[addr_q];
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Self-checking bench for block_data_memory: a table of accesses with
// expected read data fed through a scoreboard queue, plus hand-written
// sequences for back-to-back service, abort, mid-access reset and LATENCY=1.
module tb_block_data_memory;

  localparam int LAT5 = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        read, write;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait, error;
  logic [15:0] rd_count, wr_count;

  logic        rd1, wr1;
  logic [5:0]  a1;
  logic [31:0] wd1;
  logic [31:0] rdata1;
  logic        busy1, err1;
  logic [15:0] rdc1, wrc1;

  block_data_memory #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(LAT5)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .error(error), .rd_count(rd_count), .wr_count(wr_count)
  );

  block_data_memory #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .read(rd1), .write(wr1), .address(a1),
    .writedata(wd1), .readdata(rdata1), .busywait(busy1),
    .error(err1), .rd_count(rdc1), .wr_count(wrc1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] rdata;
  } sb_t;

  vec_t tbl [10];
  sb_t  sb_q [$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_rd   = 0;
  int   exp_wr   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Waits for the next negedge, drives a request and queues its expectation.
  task automatic issue(input logic rd, input logic wr, input logic [5:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rdata);
    @(negedge clk);
    read = rd; write = wr; address = a; writedata = d;
    sb_q.push_back('{is_rd: rd & ~wr, rdata: exp_rdata});
    #1 check("busy_on_request", 32'(busywait), 32'd1);
  endtask

  // Counts negedges until busywait drops (DONE), then checks outputs
  // against the scoreboard entry and optionally drops the request.
  task automatic finish(input bit drop, input logic exp_err, input int exp_cyc);
    int  cyc = 0;
    sb_t e;
    do begin
      @(negedge clk);
      cyc++;
    end while (busywait && cyc < 40);
    check("busy_cycles", 32'(cyc), 32'(exp_cyc));
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb_q.pop_front();
      if (e.is_rd) exp_rd++;
      else         exp_wr++;
      check("readdata", readdata, e.rdata);
    end
    check("rd_count", 32'(rd_count), 32'(exp_rd));
    check("wr_count", 32'(wr_count), 32'(exp_wr));
    check("error", 32'(error), 32'(exp_err));
    if (drop) begin
      read = 1'b0; write = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 6'h2A, 32'h0,        32'h0,        1'b0};
    tbl[1] = '{1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[2] = '{1'b1, 1'b0, 6'h2A, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 6'h3F, 32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 6'h00, 32'h0,        32'h0,        1'b0};
    tbl[5] = '{1'b1, 1'b0, 6'h3F, 32'h0,        32'h12345678, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 6'h00, 32'hCAFEF00D, 32'h12345678, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 6'h00, 32'h0,        32'hCAFEF00D, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 6'h10, 32'hA5A5A5A5, 32'hCAFEF00D, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 6'h10, 32'h0,        32'hA5A5A5A5, 1'b1};

    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    rd1 = 1'b0; wr1 = 1'b0; a1 = '0; wd1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busywait", 32'(busywait), 32'd0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);

    // Table-driven accesses, one at a time.
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp_rdata);
      finish(1'b1, tbl[i].exp_err, LAT5 + 1);
    end

    // Write-back then fill: the read is raised while the write is in DONE.
    issue(1'b0, 1'b1, 6'h05, 32'h11223344, 32'hA5A5A5A5);
    finish(1'b0, 1'b1, LAT5 + 1);
    write = 1'b0; read = 1'b1; address = 6'h25; writedata = 32'hFFFF0000;
    sb_q.push_back('{is_rd: 1'b1, rdata: 32'h0});
    @(negedge clk);
    check("b2b_busy_immediate", 32'(busywait), 32'd1);
    finish(1'b1, 1'b1, LAT5 + 1);
    issue(1'b1, 1'b0, 6'h05, 32'h0, 32'h11223344);
    finish(1'b1, 1'b1, LAT5 + 1);

    // Abort: request dropped and address changed during BUSY.
    issue(1'b1, 1'b0, 6'h2A, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    read = 1'b0; address = 6'h00;
    finish(1'b1, 1'b1, LAT5);

    // Reset at E2 of a write: access abandoned.
    @(negedge clk);
    write = 1'b1; address = 6'h01; writedata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy_eq_req", 32'(busywait), 32'(read | write));
    check("midrst_wr_count", 32'(wr_count), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_readdata", readdata, 32'h0);
    reset = 1'b0; write = 1'b0;
    exp_rd = 0; exp_wr = 0;
    issue(1'b1, 1'b0, 6'h01, 32'h0, 32'h0);
    finish(1'b1, 1'b0, LAT5 + 1);
    issue(1'b1, 1'b0, 6'h2A, 32'h0, 32'h0);
    finish(1'b1, 1'b0, LAT5 + 1);

    // LATENCY=1 instance: write then aborted read of address 63.
    @(negedge clk);
    wr1 = 1'b1; a1 = 6'h3F; wd1 = 32'h0000CAFE;
    @(negedge clk);
    check("l1_busy_wr", 32'(busy1), 32'd1);
    @(negedge clk);
    check("l1_done_wr", 32'(busy1), 32'd0);
    check("l1_wr_count", 32'(wrc1), 32'd1);
    check("l1_readdata_hold", rdata1, 32'h0);
    wr1 = 1'b0;
    @(negedge clk);
    rd1 = 1'b1; wd1 = 32'h0;
    #1 check("l1_busy_req", 32'(busy1), 32'd1);
    @(negedge clk);
    check("l1_busy_rd", 32'(busy1), 32'd1);
    rd1 = 1'b0; a1 = 6'h00;
    @(negedge clk);
    check("l1_done_rd", 32'(busy1), 32'd0);
    check("l1_readdata", rdata1, 32'h0000CAFE);
    check("l1_rd_count", 32'(rdc1), 32'd1);
    @(negedge clk);
    check("l1_idle_busy", 32'(busy1), 32'd0);
    check("l1_readdata_keep", rdata1, 32'h0000CAFE);
    check("l1_error", 32'(err1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
